// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-search datapath.
package rc4_pkg;

  localparam int DEFAULT_KEY_WIDTH = 24;
  localparam int DEFAULT_MSG_DEP   = 32;

  localparam logic [7:0] ASCII_LOWER_A = 8'h61;
  localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;
  localparam logic [7:0] ASCII_SPACE   = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    CHECK,
    ABORT,
    NEXT_KEY,
    FOUND,
    EXHAUSTED
  } key_search_state_t;

endpackage

// File: rtl/plaintext_byte_checker.sv
// Flags whether a decrypted byte can belong to the message (lowercase or space).
module plaintext_byte_checker
  import rc4_pkg::*;
(
  input  logic [7:0] byte_data,
  output logic       legal
);

  // Pure range test; kept separate so parallel checkers can reuse it.
  assign legal = ((byte_data >= ASCII_LOWER_A) && (byte_data <= ASCII_LOWER_Z)) ||
                 (byte_data == ASCII_SPACE);

endmodule

// File: rtl/key_search_fsm.sv
// Brute-force key search controller: walks the key space, launches a
// KSA/decrypt trial per key and screens the plaintext stream byte by byte.
module key_search_fsm
  import rc4_pkg::*;
#(
  parameter int                   KEY_WIDTH  = DEFAULT_KEY_WIDTH,
  parameter logic [KEY_WIDTH-1:0] KEY_FIRST  = '0,
  parameter logic [KEY_WIDTH-1:0] KEY_LAST   = KEY_WIDTH'(24'h3FFFFF),
  parameter logic [KEY_WIDTH-1:0] KEY_STRIDE = KEY_WIDTH'(1),
  parameter int                   MSG_DEP    = DEFAULT_MSG_DEP
) (
  input  logic                 CLOCK_50,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  output logic                 byte_ready,
  output logic [KEY_WIDTH-1:0] secret_key,
  output logic                 trial_start,
  output logic                 trial_abort,
  output logic                 busy,
  output logic                 key_found,
  output logic                 key_not_found
);

  localparam int                 CNT_W        = (MSG_DEP > 1) ? $clog2(MSG_DEP) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST     = CNT_W'(MSG_DEP - 1);
  localparam logic [KEY_WIDTH:0] KEY_LAST_EXT = {1'b0, KEY_LAST};

  key_search_state_t     state_reg, state_next;
  logic [KEY_WIDTH-1:0]  key_reg, key_next;
  logic [CNT_W-1:0]      count_reg, count_next;
  // Remembers that ABORT was entered because of stop, so it returns to IDLE.
  logic                  stop_pending_reg, stop_pending_next;

  logic                  byte_legal;
  logic                  byte_accept;
  logic [KEY_WIDTH:0]    key_sum;

  plaintext_byte_checker u_checker (
    .byte_data (byte_data),
    .legal     (byte_legal)
  );

  // Extra bit catches carry-out so the search never wraps back to key 0.
  assign key_sum     = {1'b0, key_reg} + {1'b0, KEY_STRIDE};
  assign byte_accept = (state_reg == CHECK) && byte_valid;

  // State, key and byte-count registers.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      key_reg          <= '0;
      count_reg        <= '0;
      stop_pending_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      key_reg          <= key_next;
      count_reg        <= count_next;
      stop_pending_reg <= stop_pending_next;
    end
  end

  // Next-state logic and Moore outputs decoded from the current state.
  always_comb begin
    state_next        = state_reg;
    key_next          = key_reg;
    count_next        = count_reg;
    stop_pending_next = 1'b0;

    byte_ready    = (state_reg == CHECK);
    trial_start   = (state_reg == LAUNCH);
    trial_abort   = (state_reg == ABORT);
    busy          = (state_reg == LAUNCH) || (state_reg == CHECK) ||
                    (state_reg == ABORT)  || (state_reg == NEXT_KEY);
    key_found     = (state_reg == FOUND);
    key_not_found = (state_reg == EXHAUSTED);

    case (state_reg)
      IDLE: begin
        // stop beats a simultaneous start here
        if (start && !stop) begin
          key_next   = KEY_FIRST;
          count_next = '0;
          state_next = LAUNCH;
        end
      end
      FOUND, EXHAUSTED: begin
        if (start) begin
          key_next   = KEY_FIRST;
          count_next = '0;
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        state_next = stop ? IDLE : CHECK;
      end
      CHECK: begin
        // stop overrides whatever byte arrives this cycle, even a final legal one
        if (stop) begin
          state_next        = ABORT;
          stop_pending_next = 1'b1;
        end else if (byte_accept) begin
          if (!byte_legal) begin
            state_next = ABORT;
          end else if (count_reg == CNT_LAST) begin
            state_next = FOUND;
          end else begin
            count_next = count_reg + 1'b1;
          end
        end
      end
      ABORT: begin
        state_next = (stop || stop_pending_reg) ? IDLE : NEXT_KEY;
      end
      NEXT_KEY: begin
        if (stop) begin
          state_next = IDLE;
        end else if (key_sum > KEY_LAST_EXT) begin
          // keep the last key tried visible on secret_key
          state_next = EXHAUSTED;
        end else begin
          key_next   = key_sum[KEY_WIDTH-1:0];
          count_next = '0;
          state_next = LAUNCH;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign secret_key = key_reg;

endmodule

// File: tb/tb_key_search_fsm.sv
// Scoreboard bench for key_search_fsm: three instances with different key ranges.
`timescale 1ns/1ps
module tb_key_search_fsm;

  localparam int NI = 3;
  localparam int KW = 24;
  localparam int MD = 32;

  typedef enum int {EV_TS, EV_ABORT, EV_FOUND, EV_NOTFOUND} ev_kind_e;
  typedef struct {
    int       inst;
    ev_kind_e kind;
    longint   key;
  } ev_t;

  logic          CLOCK_50 = 1'b0;
  logic          reset_n;
  logic          start_s [NI];
  logic          stop_s  [NI];
  logic          bv_s    [NI];
  logic [7:0]    bd_s    [NI];
  logic          br_s    [NI];
  logic [KW-1:0] key_s   [NI];
  logic          ts_s    [NI];
  logic          ta_s    [NI];
  logic          busy_s  [NI];
  logic          kf_s    [NI];
  logic          knf_s   [NI];

  ev_t    exp_q[$];
  int     n_checks = 0;
  int     n_fails  = 0;
  longint m_key [NI];
  logic   kf_prev  [NI];
  logic   knf_prev [NI];

  always #10 CLOCK_50 = ~CLOCK_50;

  key_search_fsm #(.KEY_WIDTH(KW), .KEY_FIRST(24'h0), .KEY_LAST(24'h2),
                   .KEY_STRIDE(24'h1), .MSG_DEP(MD)) u_dut0 (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start_s[0]), .stop(stop_s[0]),
    .byte_valid(bv_s[0]), .byte_data(bd_s[0]), .byte_ready(br_s[0]),
    .secret_key(key_s[0]), .trial_start(ts_s[0]), .trial_abort(ta_s[0]),
    .busy(busy_s[0]), .key_found(kf_s[0]), .key_not_found(knf_s[0]));

  key_search_fsm #(.KEY_WIDTH(KW), .KEY_FIRST(24'h1), .KEY_LAST(24'hA),
                   .KEY_STRIDE(24'h4), .MSG_DEP(MD)) u_dut1 (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start_s[1]), .stop(stop_s[1]),
    .byte_valid(bv_s[1]), .byte_data(bd_s[1]), .byte_ready(br_s[1]),
    .secret_key(key_s[1]), .trial_start(ts_s[1]), .trial_abort(ta_s[1]),
    .busy(busy_s[1]), .key_found(kf_s[1]), .key_not_found(knf_s[1]));

  key_search_fsm #(.KEY_WIDTH(KW), .KEY_FIRST(24'hFFFFFD), .KEY_LAST(24'hFFFFFF),
                   .KEY_STRIDE(24'h2), .MSG_DEP(MD)) u_dut2 (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start_s[2]), .stop(stop_s[2]),
    .byte_valid(bv_s[2]), .byte_data(bd_s[2]), .byte_ready(br_s[2]),
    .secret_key(key_s[2]), .trial_start(ts_s[2]), .trial_abort(ta_s[2]),
    .busy(busy_s[2]), .key_found(kf_s[2]), .key_not_found(knf_s[2]));

  // ---------------- reference model (key-space arithmetic) ----------------
  function automatic longint cfg_first(int i);
    case (i)
      0:       return 64'h0;
      1:       return 64'h1;
      default: return 64'hFFFFFD;
    endcase
  endfunction

  function automatic longint cfg_last(int i);
    case (i)
      0:       return 64'h2;
      1:       return 64'hA;
      default: return 64'hFFFFFF;
    endcase
  endfunction

  function automatic longint cfg_stride(int i);
    case (i)
      0:       return 64'h1;
      1:       return 64'h4;
      default: return 64'h2;
    endcase
  endfunction

  function automatic bit is_legal(logic [7:0] b);
    return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
  endfunction

  function automatic logic [7:0] rand_legal();
    int r;
    r = $urandom_range(0, 26);
    return (r == 26) ? 8'h20 : 8'(8'h61 + r);
  endfunction

  function automatic logic [7:0] rand_illegal();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    while (is_legal(b)) b = 8'($urandom_range(0, 255));
    return b;
  endfunction

  task automatic push_ev(int i, ev_kind_e k, longint key);
    ev_t e;
    e.inst = i;
    e.kind = k;
    e.key  = key;
    exp_q.push_back(e);
  endtask

  // Model of what follows a failed trial: next candidate or exhaustion.
  task automatic model_advance(int i);
    longint sum;
    sum = m_key[i] + cfg_stride(i);
    if (sum > cfg_last(i)) begin
      push_ev(i, EV_NOTFOUND, m_key[i]);
    end else begin
      m_key[i] = sum;
      push_ev(i, EV_TS, m_key[i]);
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(string name, longint act, longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(int i, ev_kind_e k, longint key);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fails++;
      $display("FAIL event: inst%0d %s key=%0h seen, required nothing", i, k.name(), key);
    end else begin
      e = exp_q.pop_front();
      if (e.inst != i || e.kind != k || e.key != key) begin
        n_fails++;
        $display("FAIL event: got inst%0d %s key=%0h, required inst%0d %s key=%0h",
                 i, k.name(), key, e.inst, e.kind.name(), e.key);
      end else begin
        $display("inst%0d %s key=%06h", i, k.name(), key);
      end
    end
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge CLOCK_50);
      for (int i = 0; i < NI; i++) begin
        if (ts_s[i] === 1'b1) expect_ev(i, EV_TS, longint'(key_s[i]));
        if (ta_s[i] === 1'b1) expect_ev(i, EV_ABORT, longint'(key_s[i]));
        if (kf_s[i] === 1'b1 && kf_prev[i] !== 1'b1) expect_ev(i, EV_FOUND, longint'(key_s[i]));
        if (knf_s[i] === 1'b1 && knf_prev[i] !== 1'b1) expect_ev(i, EV_NOTFOUND, longint'(key_s[i]));
        kf_prev[i]  = kf_s[i];
        knf_prev[i] = knf_s[i];
      end
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_start(int i);
    m_key[i] = cfg_first(i);
    push_ev(i, EV_TS, m_key[i]);
    start_s[i] = 1'b1;
    tick();
    start_s[i] = 1'b0;
  endtask

  // Present one byte and hold it until the controller takes it.
  task automatic feed_byte(int i, logic [7:0] b, bit with_stop);
    int n;
    n = 0;
    bv_s[i] = 1'b1;
    bd_s[i] = b;
    while (br_s[i] !== 1'b1 && n < 100) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      n_fails++;
      $display("FAIL byte_ready timeout: inst%0d got 0, required 1", i);
    end
    stop_s[i] = with_stop;
    tick();
    stop_s[i] = 1'b0;
    bv_s[i]   = 1'b0;
    bd_s[i]   = 8'h00;
  endtask

  task automatic maybe_gap();
    if ($urandom_range(0, 3) == 0) tick();
  endtask

  task automatic fail_trial(int i, int n_legal, logic [7:0] bad);
    for (int j = 0; j < n_legal; j++) begin
      feed_byte(i, rand_legal(), 1'b0);
      maybe_gap();
    end
    push_ev(i, EV_ABORT, m_key[i]);
    model_advance(i);
    feed_byte(i, bad, 1'b0);
    maybe_gap();
  endtask

  task automatic pass_trial(int i, bit fixed_a);
    push_ev(i, EV_FOUND, m_key[i]);
    for (int j = 0; j < MD; j++) begin
      feed_byte(i, fixed_a ? 8'h61 : rand_legal(), 1'b0);
      if (j < MD - 1) begin
        check("found_early", kf_s[i], 0);
        maybe_gap();
      end
    end
    check("found_after_last", kf_s[i], 1);
    check("found_busy", busy_s[i], 0);
    check("found_key", key_s[i], m_key[i]);
  endtask

  task automatic wait_not_found(int i);
    int n;
    n = 0;
    while (knf_s[i] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("not_found", knf_s[i], 1);
    check("not_found_key", key_s[i], m_key[i]);
    check("not_found_busy", busy_s[i], 0);
  endtask

  task automatic check_outputs_zero(int i);
    check("zero_busy", busy_s[i], 0);
    check("zero_ready", br_s[i], 0);
    check("zero_key", key_s[i], 0);
    check("zero_ts", ts_s[i], 0);
    check("zero_ta", ta_s[i], 0);
    check("zero_kf", kf_s[i], 0);
    check("zero_knf", knf_s[i], 0);
  endtask

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      start_s[i] = 1'b0; stop_s[i] = 1'b0; bv_s[i] = 1'b0; bd_s[i] = 8'h00;
      m_key[i] = 0; kf_prev[i] = 1'b0; knf_prev[i] = 1'b0;
    end
    fork
      monitor_loop();
    join_none

    // reset state
    #25;
    for (int i = 0; i < NI; i++) check_outputs_zero(i);
    #10 reset_n = 1'b1;
    tick();

    // pass on first key with 'a' bytes
    do_start(0);
    pass_trial(0, 1'b1);

    // early abort on 'A', next key passes with a fresh byte count
    do_start(0);
    for (int j = 0; j < 4; j++) feed_byte(0, 8'h20, 1'b0);
    fail_trial(0, 0, 8'h41);
    check("abort_next_key", m_key[0], 1);
    feed_byte(0, 8'h7A, 1'b0);
    feed_byte(0, 8'h61, 1'b0);
    push_ev(0, EV_FOUND, m_key[0]);
    for (int j = 2; j < MD; j++) feed_byte(0, 8'h20, 1'b0);
    check("boundary_found", kf_s[0], 1);
    check("boundary_key", key_s[0], 1);

    // boundary illegal bytes exhaust the 3-key range
    do_start(0);
    fail_trial(0, 3, 8'h60);
    fail_trial(0, 0, 8'h7B);
    fail_trial(0, 5, 8'h1F);
    wait_not_found(0);

    // exhaustion with 0xFF first bytes
    do_start(0);
    for (int t = 0; t < 3; t++) fail_trial(0, 0, 8'hFF);
    wait_not_found(0);

    // stride 4 from key 1, then carry-out near the top of the key space
    do_start(1);
    for (int t = 0; t < 3; t++) fail_trial(1, $urandom_range(0, 6), rand_illegal());
    wait_not_found(1);
    do_start(2);
    for (int t = 0; t < 2; t++) fail_trial(2, $urandom_range(0, 6), rand_illegal());
    wait_not_found(2);

    // stop together with the final legal byte
    do_start(0);
    for (int j = 0; j < MD - 1; j++) feed_byte(0, rand_legal(), 1'b0);
    push_ev(0, EV_ABORT, m_key[0]);
    feed_byte(0, 8'h61, 1'b1);
    repeat (4) tick();
    check("stop_busy", busy_s[0], 0);
    check("stop_found", kf_s[0], 0);
    check("stop_not_found", knf_s[0], 0);

    // start and stop together in IDLE
    start_s[0] = 1'b1; stop_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0; stop_s[0] = 1'b0;
    tick();
    check("start_stop_idle", busy_s[0], 0);

    // asynchronous reset in the middle of checking key 1
    do_start(0);
    fail_trial(0, 2, 8'h00);
    for (int j = 0; j < 3; j++) feed_byte(0, rand_legal(), 1'b0);
    @(negedge CLOCK_50);
    #3 reset_n = 1'b0;
    #1;
    check_outputs_zero(0);
    check("reset_queue", exp_q.size(), 0);
    @(negedge CLOCK_50);
    #3 reset_n = 1'b1;
    tick();
    do_start(0);
    pass_trial(0, 1'b0);

    // randomized searches
    for (int r = 0; r < 6; r++) begin
      int pass_at;
      pass_at = $urandom_range(0, 3);
      do_start(0);
      for (int t = 0; t < 3; t++) begin
        if (t == pass_at) begin
          pass_trial(0, 1'b0);
          break;
        end
        fail_trial(0, $urandom_range(0, MD - 1), rand_illegal());
      end
      if (pass_at == 3) wait_not_found(0);
    end

    repeat (5) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
